// File: rtl/alu_arbiter_if.sv
// Bus between two requesters, the shared ALU and the alu_arbiter.
// The slave modport is the arbiter's view; master is the environment's view
// (requesters plus ALU).
interface alu_arbiter_if #(
    parameter int DATA_W = 4,
    parameter int OPN_W  = 3
);
    logic              req0;
    logic              req1;
    logic [DATA_W-1:0] a0;
    logic [DATA_W-1:0] b0;
    logic [DATA_W-1:0] a1;
    logic [DATA_W-1:0] b1;
    logic [OPN_W-1:0]  opn0;
    logic [OPN_W-1:0]  opn1;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OPN_W-1:0]  alu_opn;
    logic [DATA_W-1:0] alu_out0;
    logic [DATA_W-1:0] alu_out1;
    logic [3:0]        alu_status;
    logic [DATA_W-1:0] res_out0;
    logic [DATA_W-1:0] res_out1;
    logic [3:0]        res_status;
    logic              done0;
    logic              done1;
    logic              gnt;
    logic              busy;

    modport slave (
        input  req0, req1, a0, b0, a1, b1, opn0, opn1,
        input  alu_out0, alu_out1, alu_status,
        output alu_a, alu_b, alu_opn,
        output res_out0, res_out1, res_status,
        output done0, done1, gnt, busy
    );

    modport master (
        output req0, req1, a0, b0, a1, b1, opn0, opn1,
        output alu_out0, alu_out1, alu_status,
        input  alu_a, alu_b, alu_opn,
        input  res_out0, res_out1, res_status,
        input  done0, done1, gnt, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared, fixed-latency ALU.
// One operation in flight at a time: IDLE -> WAIT (ALU_LAT+1 cycles) -> DONE.
// Optional feature macro ALU_ARB_RR_EN: round-robin on simultaneous requests;
// when undefined, requester 0 has fixed priority.
module alu_arbiter #(
    parameter int DATA_W  = 4,
    parameter int OPN_W   = 3,
    parameter int ALU_LAT = 1
) (
    input logic           clk,
    input logic           rst,
    alu_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT);

    state_t            r_state;
    state_t            w_nextState;
    logic [3:0]        r_waitCnt;
    logic [DATA_W-1:0] r_aluA;
    logic [DATA_W-1:0] r_aluB;
    logic [OPN_W-1:0]  r_aluOpn;
    logic [DATA_W-1:0] r_res0;
    logic [DATA_W-1:0] r_res1;
    logic [3:0]        r_resStatus;
    logic              r_gnt;
    logic              w_anyReq;
    logic              w_winner;
    logic              w_issue;
    logic              w_capture;

    assign w_anyReq = bus.req0 | bus.req1;

`ifdef ALU_ARB_RR_EN
    logic r_lastGnt;

    // Remember who was granted at the last issue so a tie goes to the other one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lastGnt <= 1'b1;
        end else if (w_issue) begin
            r_lastGnt <= w_winner;
        end
    end

    // Tie -> requester not granted last; otherwise whoever is asking.
    always_comb begin
        w_winner = bus.req1;
        if (bus.req0 && bus.req1) begin
            w_winner = ~r_lastGnt;
        end
    end
`else
    // Fixed priority: requester 1 only wins when requester 0 is quiet.
    always_comb begin
        w_winner = ~bus.req0;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic plus the issue/capture strobes that drive the datapath.
    always_comb begin
        w_nextState = r_state;
        w_issue     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_anyReq) begin
                    w_issue     = 1'b1;
                    w_nextState = WAIT;
                end
            end
            WAIT: begin
                if (r_waitCnt == 4'd0) begin
                    w_capture   = 1'b1;
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Wait counter: loaded with ALU_LAT at issue, WAIT ends when it reaches zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_waitCnt <= 4'd0;
        end else if (w_issue) begin
            r_waitCnt <= LAT_LOAD;
        end else if (r_state == WAIT && r_waitCnt != 4'd0) begin
            r_waitCnt <= r_waitCnt - 4'd1;
        end
    end

    // Operand latch at issue and result capture at the end of WAIT; both hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_aluA      <= '0;
            r_aluB      <= '0;
            r_aluOpn    <= '0;
            r_gnt       <= 1'b0;
            r_res0      <= '0;
            r_res1      <= '0;
            r_resStatus <= '0;
        end else begin
            if (w_issue) begin
                r_aluA   <= w_winner ? bus.a1   : bus.a0;
                r_aluB   <= w_winner ? bus.b1   : bus.b0;
                r_aluOpn <= w_winner ? bus.opn1 : bus.opn0;
                r_gnt    <= w_winner;
            end
            if (w_capture) begin
                r_res0      <= bus.alu_out0;
                r_res1      <= bus.alu_out1;
                r_resStatus <= bus.alu_status;
            end
        end
    end

    assign bus.alu_a      = r_aluA;
    assign bus.alu_b      = r_aluB;
    assign bus.alu_opn    = r_aluOpn;
    assign bus.res_out0   = r_res0;
    assign bus.res_out1   = r_res1;
    assign bus.res_status = r_resStatus;
    assign bus.gnt        = r_gnt;
    assign bus.busy       = (r_state != IDLE);
    assign bus.done0      = (r_state == DONE) & ~r_gnt;
    assign bus.done1      = (r_state == DONE) &  r_gnt;
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_W, 4, operand/result width.
REQ-002 Parameter OPN_W, 3, opcode width.
REQ-003 Parameter ALU_LAT, 1, ALU input-to-output latency in cycles, legal range 0..15.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 req0, req1  in  1  request from requester 0/1; held high with operands stable until matching done pulse.
REQ-007 a0, b0 / a1, b1  in  DATA_W  operands of requester 0/1.
REQ-008 opn0 / opn1  in  OPN_W  opcode of requester 0/1.
REQ-009 alu_a, alu_b  out  DATA_W  registered operands driven to the shared ALU.
REQ-010 alu_opn  out  OPN_W  registered opcode driven to the ALU.
REQ-011 alu_out0, alu_out1  in  DATA_W  ALU results.
REQ-012 alu_status  in  4  ALU status flags.
REQ-013 res_out0, res_out1  out  DATA_W  captured ALU results.
REQ-014 res_status  out  4  captured ALU status.
REQ-015 done0, done1  out  1  one-cycle pulse, result ready for requester 0/1.
REQ-016 gnt  out  1  index of requester currently or last served.
REQ-017 busy  out  1  high whenever state is not IDLE.

Function
REQ-018 FSM states IDLE, WAIT, DONE; only one operation in flight.
REQ-019 IDLE: no request -> stay IDLE; any request -> arbitrate, latch winner's a/b/opn into alu_a/alu_b/alu_opn, set gnt, load wait counter, go WAIT.
REQ-020 Single request -> that requester wins; both requesting -> arbitration per REQ-030/REQ-031.
REQ-021 WAIT lasts exactly ALU_LAT+1 cycles; on the edge ending the last WAIT cycle, capture alu_out0/alu_out1/alu_status into res_*, go DONE.
REQ-022 DONE lasts one cycle: done[gnt]=1, other done=0; next state IDLE unconditionally.
REQ-023 Latency: request seen in IDLE in cycle 0 -> alu_* valid from cycle 1 -> done pulse in cycle 2+ALU_LAT (cycle 3 at default).
REQ-024 alu_a/alu_b/alu_opn hold latched values from issue until the next issue; never change during WAIT or DONE.
REQ-025 res_* hold until the next capture.
REQ-026 Requests are sampled only in IDLE; request changes during WAIT/DONE are ignored.
REQ-027 Request still high in the cycle after DONE is treated as a new request; back-to-back ops from one requester run every ALU_LAT+3 cycles.
REQ-028 done0 and done1 are never high together.

Reset
REQ-029 rst=1 at a clock edge: state IDLE, alu_a/alu_b/alu_opn=0, res_out0/res_out1/res_status=0, done0/done1=0, busy=0, gnt=0, last-grant=1, wait counter=0; an in-flight operation is dropped and no done pulse is issued for it.

Configuration
REQ-030 Macro ALU_ARB_RR_EN defined: round-robin on simultaneous requests; winner is the requester not granted last; last-grant resets to 1 so requester 0 wins the first tie; last-grant updates at each issue.
REQ-031 ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins ties; last-grant register not implemented.

Verification
REQ-032 ALU model with ALU_LAT=1 (registered add); req0 with a0=3, b0=7, opn0=0 at cycle 0 -> alu_a=3, alu_b=7, alu_opn=0 from cycle 1; done0=1 only in cycle 3 with res_out0=10; done1 stays 0.
REQ-033 req0 and req1 both high, held (a0=1,b0=2; a1=4,b1=5) -> RR: grants 0,1,0,1 with done pulses every 4 cycles; fixed priority: requester 0 served every 4 cycles, done1 never pulses.
REQ-034 req1 alone with a1=15, b1=1 -> done1 in cycle 3, res_out0 = model value 0 (4-bit wrap), gnt=1.
REQ-035 rst=1 in cycle 2 of an op started at cycle 0 -> cycle 3 all outputs 0, no done pulse; op restarts only after new request in IDLE.
REQ-036 req1 asserted in cycle 1 while requester 0 is in WAIT -> ignored until IDLE in cycle 4, then issued; done1 in cycle 7.
REQ-037 ALU_LAT=0 and ALU_LAT=3 builds: done pulse in cycle 2 and cycle 5 respectively for a cycle-0 request.
